// File: rtl/sat_counter_table.sv
// sat_counter_table
//   Table of 2**IDX_W independent CTR_W-bit saturating counters for the
//   fetch-stage branch predictor. Fetch issues lookups; branch resolution
//   issues trains. One lookup and one train may be accepted every cycle.
//   The lookup response is registered and appears one cycle after the request.
//
// Parameters:
//   CTR_W     counter width in bits (1..8)
//   IDX_W     index width; the table holds 2**IDX_W entries
//   RESET_VAL value loaded into every counter on reset (< 2**CTR_W)
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high reset
//   lookup_valid  lookup request this cycle
//   lookup_idx    lookup index
//   rsp_valid     response valid, one cycle after lookup_valid
//   rsp_taken     prediction (MSB of the addressed counter)
//   rsp_ctr       full value of the addressed counter
//   train_valid   train request this cycle
//   train_idx     train index
//   train_taken   1 = increment, 0 = decrement
//
// Optional build macro:
//   SAT_COUNTER_TABLE_GSHARE_EN  adds an IDX_W-bit global history register.
//   Both indices are XORed with the history (pre-update value), and every
//   train shifts train_taken into the history.

module sat_counter_table #(
  parameter int CTR_W     = 2,
  parameter int IDX_W     = 5,
  parameter int RESET_VAL = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lookup_valid,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             rsp_valid,
  output logic             rsp_taken,
  output logic [CTR_W-1:0] rsp_ctr,
  input  logic             train_valid,
  input  logic [IDX_W-1:0] train_idx,
  input  logic             train_taken
);

  localparam int               ENTRIES = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(RESET_VAL);

  logic [CTR_W-1:0] ctr_q [ENTRIES];
  logic [IDX_W-1:0] lkp_eff;
  logic [IDX_W-1:0] trn_eff;
  logic [CTR_W-1:0] trn_old;
  logic [CTR_W-1:0] trn_new;
  logic             rsp_valid_q;
  logic             rsp_valid_d;
  logic [CTR_W-1:0] rsp_ctr_q;
  logic [CTR_W-1:0] rsp_ctr_d;

`ifdef SAT_COUNTER_TABLE_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;
  logic [IDX_W-1:0] ghr_d;

  // Both ports hash with the history as it stands this cycle.
  assign lkp_eff = lookup_idx ^ ghr_q;
  assign trn_eff = train_idx ^ ghr_q;

  generate
    if (IDX_W == 1) begin : g_ghr_1
      always_comb begin
        ghr_d = ghr_q;
        if (train_valid) ghr_d = train_taken;
      end
    end else begin : g_ghr_n
      always_comb begin
        ghr_d = ghr_q;
        if (train_valid) ghr_d = {ghr_q[IDX_W-2:0], train_taken};
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end
`else
  assign lkp_eff = lookup_idx;
  assign trn_eff = train_idx;
`endif

  // Saturating step by explicit end-value compare, so no wrap at either end.
  always_comb begin
    trn_old = ctr_q[trn_eff];
    trn_new = trn_old;
    if (train_taken) begin
      if (trn_old != CTR_MAX) trn_new = trn_old + CTR_W'(1);
    end else begin
      if (trn_old != '0) trn_new = trn_old - CTR_W'(1);
    end
  end

  // Write-first: a same-cycle train to the looked-up entry is returned.
  always_comb begin
    rsp_valid_d = lookup_valid;
    rsp_ctr_d   = rsp_ctr_q;
    if (lookup_valid) begin
      if (train_valid && (trn_eff == lkp_eff)) rsp_ctr_d = trn_new;
      else                                     rsp_ctr_d = ctr_q[lkp_eff];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RST;
    end else if (train_valid) begin
      ctr_q[trn_eff] <= trn_new;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_ctr_q   <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_ctr_q   <= rsp_ctr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_ctr   = rsp_ctr_q;
  assign rsp_taken = rsp_ctr_q[CTR_W-1];

endmodule

// File: tb/tb_sat_counter_table.sv
module tb_sat_counter_table;

  logic       clk = 1'b0;
  logic       reset;
  logic       lookup_valid;
  logic [4:0] lookup_idx;
  logic       rsp_valid;
  logic       rsp_taken;
  logic [1:0] rsp_ctr;
  logic       train_valid;
  logic [4:0] train_idx;
  logic       train_taken;

  int checks   = 0;
  int failures = 0;

  sat_counter_table #(.CTR_W(2), .IDX_W(5), .RESET_VAL(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .lookup_valid (lookup_valid),
    .lookup_idx   (lookup_idx),
    .rsp_valid    (rsp_valid),
    .rsp_taken    (rsp_taken),
    .rsp_ctr      (rsp_ctr),
    .train_valid  (train_valid),
    .train_idx    (train_idx),
    .train_taken  (train_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       lv;
    logic [4:0] li;
    logic       tv;
    logic [4:0] ti;
    logic       tt;
    logic       ev;
    logic [1:0] ec;
    logic       et;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic lv, int li, logic tv, int ti, logic tt,
                              logic ev, int ec, logic et);
    vec_t v;
    v.lv = lv; v.li = 5'(li); v.tv = tv; v.ti = 5'(ti); v.tt = tt;
    v.ev = ev; v.ec = 2'(ec); v.et = et;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic check_rsp(input string nm, input logic ev, input logic [1:0] ec,
                           input logic et);
    check({nm, ".rsp_valid"}, int'(rsp_valid), int'(ev));
    check({nm, ".rsp_ctr"},   int'(rsp_ctr),   int'(ec));
    check({nm, ".rsp_taken"}, int'(rsp_taken), int'(et));
  endtask

  // Drive one cycle of inputs, then check the outputs just after the edge.
  task automatic apply(input vec_t v, input string nm);
    @(negedge clk);
    lookup_valid = v.lv; lookup_idx = v.li;
    train_valid  = v.tv; train_idx  = v.ti; train_taken = v.tt;
    @(posedge clk);
    #1;
    check_rsp(nm, v.ev, v.ec, v.et);
  endtask

  task automatic idle_inputs();
    lookup_valid = 1'b0; lookup_idx = '0;
    train_valid  = 1'b0; train_idx  = '0; train_taken = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_rsp("reset", 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

`ifdef SAT_COUNTER_TABLE_GSHARE_EN
    //          lv li  tv ti tt   ev ec et
    vecs.push_back(mk(0, 0,  1, 0, 1,  0, 0, 0)); // E=0 -> 2, ghr=00001
    vecs.push_back(mk(1, 1,  0, 0, 0,  1, 2, 1)); // L=1^1=0
    vecs.push_back(mk(1, 0,  0, 0, 0,  1, 1, 0)); // L=0^1=1
    vecs.push_back(mk(1, 1,  1, 1, 1,  1, 3, 1)); // both hash to 0 with old ghr
    vecs.push_back(mk(1, 3,  0, 0, 0,  1, 3, 1)); // ghr=00011, L=0
    vecs.push_back(mk(1, 2,  0, 0, 0,  1, 1, 0)); // L=1
    foreach (vecs[i]) apply(vecs[i], $sformatf("gshare%0d", i));
`else
    //          lv li  tv ti tt   ev ec et
    vecs.push_back(mk(1, 0,  0, 0, 0,  1, 1, 0));
    vecs.push_back(mk(1, 7,  0, 0, 0,  1, 1, 0));
    vecs.push_back(mk(1, 31, 0, 0, 0,  1, 1, 0));
    vecs.push_back(mk(0, 0,  0, 0, 0,  0, 1, 0)); // response holds
    vecs.push_back(mk(0, 0,  1, 3, 1,  0, 1, 0)); // ctr3 = 2
    vecs.push_back(mk(0, 0,  1, 3, 1,  0, 1, 0)); // 3
    vecs.push_back(mk(0, 0,  1, 3, 1,  0, 1, 0)); // 3 (sat)
    vecs.push_back(mk(0, 0,  1, 3, 1,  0, 1, 0)); // 3 (sat)
    vecs.push_back(mk(1, 3,  0, 0, 0,  1, 3, 1));
    vecs.push_back(mk(1, 3,  1, 3, 1,  1, 3, 1)); // still saturated
    vecs.push_back(mk(1, 4,  0, 0, 0,  1, 1, 0)); // neighbour untouched
    vecs.push_back(mk(0, 0,  1, 5, 0,  0, 1, 0)); // ctr5 = 0
    vecs.push_back(mk(0, 0,  1, 5, 0,  0, 1, 0)); // 0 (sat)
    vecs.push_back(mk(1, 5,  1, 5, 0,  1, 0, 0)); // 0, no wrap
    vecs.push_back(mk(1, 5,  0, 0, 0,  1, 0, 0));
    vecs.push_back(mk(0, 0,  1, 5, 1,  0, 0, 0)); // ctr5 = 1
    vecs.push_back(mk(1, 5,  0, 0, 0,  1, 1, 0));
    vecs.push_back(mk(1, 9,  1, 9, 1,  1, 2, 1)); // write-first
    vecs.push_back(mk(1, 9,  1, 9, 1,  1, 3, 1));
    vecs.push_back(mk(1, 9,  1, 9, 0,  1, 2, 1));
    vecs.push_back(mk(1, 10, 1, 9, 0,  1, 1, 0)); // ctr9 = 1
    vecs.push_back(mk(1, 9,  1, 10, 1, 1, 1, 0)); // ctr10 = 2
    vecs.push_back(mk(1, 10, 0, 0, 0,  1, 2, 1));
    vecs.push_back(mk(1, 12, 0, 0, 0,  1, 1, 0));
    vecs.push_back(mk(0, 0,  1, 12, 1, 0, 1, 0)); // train after lookup: not seen
    vecs.push_back(mk(1, 12, 0, 0, 0,  1, 2, 1));
    vecs.push_back(mk(0, 0,  1, 2, 1,  0, 2, 1)); // ctr2 = 2
    vecs.push_back(mk(0, 0,  1, 2, 1,  0, 2, 1)); // ctr2 = 3
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset in the same cycle as a lookup and a train: both ignored,
    // no response pulse, counters back to the reset value.
    @(negedge clk);
    reset = 1'b1;
    lookup_valid = 1'b1; lookup_idx = 5'd2;
    train_valid  = 1'b1; train_idx  = 5'd2; train_taken = 1'b1;
    @(posedge clk);
    #1;
    check_rsp("midreset", 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    check_rsp("postreset_idle", 1'b0, 2'd0, 1'b0);
    apply(mk(1, 2, 0, 0, 0, 1, 1, 0), "postreset_lookup2");
`endif

    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #1;
    check("final_idle.rsp_valid", int'(rsp_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
